// File: rtl/dig_display_pkg.sv
// Types and helpers shared by the seven-segment display controller.
`include "defines.vh"

package dig_display_pkg;
  localparam int DIG_NUM = `DIG_NUM;
  localparam int DIG_W   = $clog2(DIG_NUM);

  typedef logic [DIG_W-1:0] dig_idx_t;
  typedef logic [6:0]       seg7_t;

  // Active-low one-hot enable for the selected digit.
  function automatic logic [DIG_NUM-1:0] dig_en_mask(input dig_idx_t idx);
    return ~(DIG_NUM'(1) << idx);
  endfunction
endpackage

// File: rtl/defines.vh
// Shared peripheral constants: bus addresses and display-wide constants.
`ifndef DIG_DEFINES_VH
`define DIG_DEFINES_VH

`define PERI_ADDR_LED 32'h1000_0000
`define PERI_ADDR_DIG 32'h1000_0010

`define SEG_OFF 8'hFF
`define DIG_NUM 8

`endif

// File: rtl/dig_display_seg7_decode.sv
// Hex nibble to active-low a..g segment pattern (bit0=a .. bit6=g).
import dig_display_pkg::*;

module seg7_decode (
  input  logic [3:0] nibble,
  output seg7_t      seg7
);
  always_comb begin
    seg7 = 7'h7F;
    case (nibble)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
      default: seg7 = 7'h7F;
    endcase
  end
endmodule

// File: rtl/dig_display.sv
// 8-digit multiplexed seven-segment controller for a write-only bus register.
// Optional build macro DIG_BLANK_LEADING_ZERO_EN blanks leading zero digits.
`include "defines.vh"
import dig_display_pkg::*;

module dig_display #(
  parameter int          SCAN_DIV  = 25000,
  parameter logic [31:0] RST_VALUE = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  addr,
  input  logic         we,
  input  logic [31:0]  wdata,
  output logic [7:0]   dig_en,
  output logic [7:0]   seg
);
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic [31:0]      data_reg;
  logic [CNT_W-1:0] scan_cnt_reg;
  dig_idx_t         idx_reg;
  logic [7:0]       dig_en_reg;
  logic [7:0]       seg_reg;

  logic [3:0] nibble;
  seg7_t      seg7;
  logic       blank;
  logic       wr_hit;

  assign wr_hit = we && (addr == `PERI_ADDR_DIG);
  assign nibble = data_reg[4*idx_reg +: 4];

  seg7_decode u_decode (
    .nibble (nibble),
    .seg7   (seg7)
  );

`ifdef DIG_BLANK_LEADING_ZERO_EN
  // upper_zero[i]: every nibble at position i and above is zero; digit 0 never blanks.
  logic [DIG_NUM-1:0] upper_zero;
  assign upper_zero[0] = 1'b0;
  for (genvar gi = 1; gi < DIG_NUM; gi++) begin : g_upper_zero
    assign upper_zero[gi] = (data_reg[31:4*gi] == '0);
  end
  assign blank = upper_zero[idx_reg];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg     <= RST_VALUE;
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
      dig_en_reg   <= `SEG_OFF;
      seg_reg      <= `SEG_OFF;
    end else begin
      if (wr_hit) begin
        data_reg <= wdata;
      end

      if (scan_cnt_reg == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt_reg <= '0;
        idx_reg      <= idx_reg + 1'b1;
      end else begin
        scan_cnt_reg <= scan_cnt_reg + 1'b1;
      end

      // Outputs follow the pre-edge idx/data, so enable and segments always switch together.
      dig_en_reg <= dig_en_mask(idx_reg);
      seg_reg    <= blank ? `SEG_OFF : {1'b1, seg7};
    end
  end

  assign dig_en = dig_en_reg;
  assign seg    = seg_reg;
endmodule
